// File: rtl/commit_trace_sequencer.sv
// Dual-issue commit PC buffer replayed one-per-cycle with sequence tags and halt/drain.
// Optional statistics counters: define COMMIT_TRACE_SEQUENCER_STATS_EN.
module commit_trace_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid1,
  input  logic [DATA_WIDTH-1:0] in_pc1,
  input  logic                  in_valid2,
  input  logic [DATA_WIDTH-1:0] in_pc2,
  output logic                  in_ready,
  input  logic                  halt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [31:0]           out_seq,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  ovf
`ifdef COMMIT_TRACE_SEQUENCER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_commits,
  output logic [CNT_WIDTH-1:0]  stat_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [31:0]           seq;
  logic [DATA_WIDTH-1:0] last_pc;
  logic                  xfer;
  logic [CW-1:0]         n_enq, n_deq;

  always_comb begin
    in_ready  = (state == RUN) && (count <= CW'(DEPTH - 2));
    out_valid = (count != '0) && (state != DONE);
    done      = (state == DONE);
    xfer      = out_valid && out_ready;
    n_deq     = xfer ? CW'(1) : '0;
    n_enq     = '0;
    if (in_ready) n_enq = CW'(in_valid1) + CW'(in_valid2);
    // Empty FIFO keeps showing the last delivered PC, not stale storage.
    out_pc    = (count != '0) ? mem[rd_ptr] : last_pc;
    out_seq   = seq;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (halt) state_nx = DRAIN;
      DRAIN:   if (count == '0) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      seq     <= '0;
      last_pc <= '0;
      ovf     <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count + n_enq - n_deq;
      wr_ptr <= wr_ptr + AW'(n_enq);
      if (xfer) begin
        rd_ptr  <= rd_ptr + AW'(1);
        seq     <= seq + 32'd1;
        last_pc <= mem[rd_ptr];
      end
      if ((state == RUN) && !in_ready && (in_valid1 || in_valid2)) ovf <= 1'b1;
    end
  end

  // Valid slots are packed at wr_ptr, older slot first.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      if (in_valid1) begin
        mem[wr_ptr] <= in_pc1;
        if (in_valid2) mem[wr_ptr + AW'(1)] <= in_pc2;
      end else if (in_valid2) begin
        mem[wr_ptr] <= in_pc2;
      end
    end
  end

`ifdef COMMIT_TRACE_SEQUENCER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_commits      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (xfer && (stat_commits != '1)) stat_commits <= stat_commits + CNT_WIDTH'(1);
      if (out_valid && !out_ready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Scoreboard bench for commit_trace_sequencer: queue-based reference model plus transfer monitor.
module tb_commit_trace_sequencer;

  localparam int DEPTH = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic [31:0] in_pc1 = '0, in_pc2 = '0;
  logic        in_ready, halt = 1'b0;
  logic        out_valid, out_ready = 1'b0, done, ovf;
  logic [31:0] out_pc, out_seq;
`ifdef COMMIT_TRACE_SEQUENCER_STATS_EN
  logic [63:0] stat_commits, stat_stall_cycles;
`endif

  commit_trace_sequencer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid1(in_valid1), .in_pc1(in_pc1),
    .in_valid2(in_valid2), .in_pc2(in_pc2),
    .in_ready(in_ready), .halt(halt),
    .out_valid(out_valid), .out_pc(out_pc), .out_seq(out_seq),
    .out_ready(out_ready), .done(done), .ovf(ovf)
`ifdef COMMIT_TRACE_SEQUENCER_STATS_EN
    , .stat_commits(stat_commits), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] seq; } ent_t;
  ent_t sb[$];

  int          tests = 0, fails = 0;
  int          mcnt = 0, mst = M_RUN;
  bit          movf = 0, just_reset = 0;
  logic [31:0] mseq = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    sb.push_back('{pc: pc, seq: mseq});
    mseq = mseq + 32'd1;
  endtask

  // One clock cycle: drive inputs, check handshake outputs against the model, advance the model.
  task automatic cyc(input bit r, input bit v1, input logic [31:0] p1, input bit v2,
                     input logic [31:0] p2, input bit h, input bit ordy);
    bit e_rdy, e_ov;
    int old_cnt, nenq;
    @(negedge clk);
    rst = r; in_valid1 = v1; in_pc1 = p1; in_valid2 = v2; in_pc2 = p2;
    halt = h; out_ready = ordy;
    #1;
    e_rdy = (mst == M_RUN) && ((DEPTH - mcnt) >= 2);
    e_ov  = (mcnt != 0) && (mst != M_DONE);
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("done", 64'(done), 64'(mst == M_DONE));
    chk("ovf", 64'(ovf), 64'(movf));
    if (just_reset) begin
      chk("reset_out_pc", 64'(out_pc), 64'd0);
      chk("reset_out_seq", 64'(out_seq), 64'd0);
      just_reset = 0;
    end
    if (!r) begin
      mcnt = 0; mst = M_RUN; movf = 0; mseq = '0; sb.delete(); just_reset = 1;
      return;
    end
    old_cnt = mcnt;
    nenq = 0;
    if (e_rdy) begin
      if (v1) begin push(p1); nenq++; end
      if (v2) begin push(p2); nenq++; end
    end else if ((mst == M_RUN) && (v1 || v2)) begin
      movf = 1;
    end
    mcnt = mcnt + nenq - ((e_ov && ordy) ? 1 : 0);
    if ((mst == M_RUN) && h) mst = M_DRAIN;
    else if ((mst == M_DRAIN) && (old_cnt == 0)) mst = M_DONE;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1, 0, '0, 0, '0, 0, ordy);
  endtask

  task automatic do_reset();
    cyc(0, 0, '0, 0, '0, 0, 0);
  endtask

  // Monitor: every accepted head entry must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'(out_pc), 64'hDEAD_0000);
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("out_seq", 64'(out_seq), 64'(e.seq));
        end
      end
    end
  end

  initial begin
    do_reset();
    idle(1, 1);

    // Dual commit in order, then single younger-slot commit.
    cyc(1, 1, 32'h1C00_0000, 1, 32'h1C00_0004, 0, 1);
    idle(3, 1);
    cyc(1, 0, 32'hFFFF_FFFF, 1, 32'h0000_0080, 0, 1);
    idle(3, 1);

    // Fill with sink stalled: in_ready falls at count 7, next attempt flags ovf.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 32'h1000 + 32'(8 * i), 1, 32'h1004 + 32'(8 * i), 0, 0);
    cyc(1, 1, 32'h2000, 0, '0, 0, 0);
    cyc(1, 1, 32'h3000, 1, 32'h3004, 0, 0);
    idle(2, 0);
    idle(10, 1);

    // Halt with three queued entries: drain then done.
    do_reset();
    cyc(1, 1, 32'hA0, 1, 32'hA4, 0, 0);
    cyc(1, 1, 32'hA8, 0, '0, 1, 0);
    cyc(1, 1, 32'hB0, 1, 32'hB4, 1, 1);
    idle(6, 1);

    // Sequence number wrap.
    do_reset();
    idle(1, 1);
    force dut.seq = 32'hFFFF_FFFE;
    idle(1, 1);
    release dut.seq;
    mseq = 32'hFFFF_FFFE;
    cyc(1, 1, 32'hC0, 1, 32'hC4, 0, 1);
    cyc(1, 1, 32'hC8, 0, '0, 0, 1);
    idle(4, 1);

    // Reset with entries still buffered.
    do_reset();
    cyc(1, 1, 32'hD0, 1, 32'hD4, 0, 0);
    cyc(1, 1, 32'hD8, 1, 32'hDC, 0, 0);
    cyc(1, 0, '0, 1, 32'hE0, 0, 0);
    do_reset();
    cyc(1, 1, 32'hF0, 0, '0, 0, 1);
    idle(3, 1);

    // Randomised traffic with occasional halts and resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ((mst == M_DONE && ($urandom % 4) == 0) || ($urandom % 400) == 0) begin
        do_reset();
      end else begin
        cyc(1, 1'($urandom % 2), $urandom, 1'($urandom % 2), $urandom,
            1'(($urandom % 150) == 0), 1'(($urandom % 4) != 0));
      end
    end
    idle(DEPTH + 4, 1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commit_trace_sequencer.md
Name: commit_trace_sequencer

Overview:
- Sits between the dual-issue commit stage and the single-port commit trace sink (DPI-C PC reporter / difftest step).
- Accepts up to two retired-PC events per cycle, slot 1 older than slot 2, and buffers them in a FIFO.
- Replays them one per cycle, in program order, over a valid/ready handshake, tagged with a running sequence number.
- Handles end-of-simulation halt: stops intake, drains the FIFO, then reports done.

Parameters:
- DATA_WIDTH, 32, width of PC fields.
- DEPTH, 8, FIFO entries; power of two, >= 4.
- CNT_WIDTH, 64, width of statistics counters (optional feature only).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- in_valid1  input  1  slot 1 (older) commit valid.
- in_pc1  input  DATA_WIDTH  slot 1 PC.
- in_valid2  input  1  slot 2 (younger) commit valid.
- in_pc2  input  DATA_WIDTH  slot 2 PC.
- in_ready  output  1  block can accept two events this cycle.
- halt  input  1  stop request from the simulation-end logic.
- out_valid  output  1  head entry valid.
- out_pc  output  DATA_WIDTH  head entry PC.
- out_seq  output  32  sequence number of the head entry.
- out_ready  input  1  sink accepts the head entry.
- done  output  1  drain complete.
- ovf  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0 at a clk edge):
  - count=0, rd_ptr=wr_ptr=0, seq=0, state=RUN.
  - Outputs: out_valid=0, done=0, ovf=0, out_pc=0, out_seq=0.
- in_ready (combinational): 1 when state==RUN and (DEPTH-count)>=2. Uses the current count; a same-cycle dequeue does not count as freed space.
- Enqueue (in_ready=1, any in_validX=1):
  - Valid slots are written compacted at wr_ptr, slot 1 first.
  - Only in_valid2 set: one entry (pc2). Both set: two entries, pc1 then pc2.
  - wr_ptr advances by 1 or 2, modulo DEPTH.
- Dequeue:
  - out_valid = (count!=0) and state!=DONE.
  - out_pc = entry[rd_ptr]; out_seq = seq.
  - A transfer occurs when out_valid and out_ready; then rd_ptr+=1 mod DEPTH and seq+=1, wrapping 0xFFFFFFFF->0.
  - out_pc/out_seq must hold stable while out_valid=1 and out_ready=0.
- Latency: an entry enqueued at edge N is presentable from cycle N+1. Minimum in-to-out latency is 1 cycle; no bypass path.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq, with n_enq in {0,1,2} and n_deq in {0,1}. count width is log2(DEPTH)+1.
- Full/empty:
  - count==DEPTH-1 or DEPTH: in_ready=0.
  - count==0: out_valid=0, out_pc holds its last value.
- ovf: set when state==RUN, in_ready=0, and (in_valid1|in_valid2). Those events are dropped. ovf clears only on reset.
- FSM:
  - RUN: intake enabled. On halt=1 go to DRAIN at the next edge; events presented in the halt cycle with in_ready=1 are still accepted.
  - DRAIN: in_ready=0, dequeue continues. When count==0, go to DONE.
  - DONE: done=1, in_ready=0, out_valid=0. Terminal until reset; halt is ignored.
  - In DRAIN/DONE, in_valid is ignored and does not set ovf.
- Reset mid-operation: all buffered entries are discarded, seq returns to 0, and the next entry out after reset has out_seq=0.

Optional Feature:
- Macro: COMMIT_TRACE_SEQUENCER_STATS_EN.
- Defined: adds output ports stat_commits [CNT_WIDTH] and stat_stall_cycles [CNT_WIDTH], both reset to 0.
  - stat_commits increments per dequeue transfer.
  - stat_stall_cycles increments each cycle with out_valid=1 and out_ready=0.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Both slots valid (pc1=0x1C000000, pc2=0x1C000004), out_ready=1 -> out_pc 0x1C000000 with seq 0 at cycle+1, then 0x1C000004 with seq 1 at cycle+2.
- Only in_valid2 (pc2=0x80) -> single entry out_pc=0x80; no spurious slot 1 entry.
- out_ready=0, DEPTH=8, dual enqueue each cycle -> in_ready drops once count reaches 7. A further enqueue attempt sets ovf=1. Then out_ready=1 -> 8 entries out in order with seq 0..7.
- halt pulsed with 3 entries queued, out_ready=1 -> in_ready=0 next cycle, 3 transfers, done=1 the cycle after the FIFO empties, out_valid=0.
- Preload seq to 0xFFFFFFFE via 2^32-2 transfers (or force) -> seq sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- rst=0 asserted while 5 entries queued -> next cycle count=0, out_valid=0, ovf=0, done=0; first post-reset entry emerges with out_seq=0.
